// File: rtl/npc_pkg.sv
// Shared NPC core constants: RV32I opcodes, alu_op one-hot bit positions and
// the issue-stage state encoding.
package npc_pkg;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam int ALU_AUIPC = 0;
  localparam int ALU_LUI   = 1;
  localparam int ALU_JAL   = 2;
  localparam int ALU_JALR  = 3;
  localparam int ALU_ADDI  = 4;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/idu_decode.sv
// Purely combinational RV32I-subset decoder: one-hot alu_op, immediate,
// write enable and ebreak/illegal flags.
module idu_decode
  import npc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 32
) (
  input  logic [31:0]     inst_i,
  output logic [OP_W-1:0] alu_op_o,
  output logic [XLEN-1:0] imm_o,
  output logic            rd_wen_o,
  output logic            ebreak_o,
  output logic            illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];

  always_comb begin
    alu_op_o  = '0;
    imm_o     = '0;
    ebreak_o  = 1'b0;
    illegal_o = 1'b0;
    if (inst_i == INST_EBREAK) begin
      ebreak_o = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI: begin
          alu_op_o[ALU_LUI] = 1'b1;
          imm_o = {inst_i[31:12], 12'b0};
        end
        OPC_AUIPC: begin
          alu_op_o[ALU_AUIPC] = 1'b1;
          imm_o = {inst_i[31:12], 12'b0};
        end
        OPC_JAL: begin
          alu_op_o[ALU_JAL] = 1'b1;
          imm_o = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        end
        OPC_JALR: begin
          if (funct3 == 3'b000) begin
            alu_op_o[ALU_JALR] = 1'b1;
            imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
          end else begin
            illegal_o = 1'b1;
          end
        end
        OPC_OPIMM: begin
          if (funct3 == 3'b000) begin
            alu_op_o[ALU_ADDI] = 1'b1;
            imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
          end else begin
            illegal_o = 1'b1;
          end
        end
        default: illegal_o = 1'b1;
      endcase
    end
  end

  // writes to x0 are dropped here so the EXU never needs to special-case rd
  assign rd_wen_o = (|alu_op_o) && (inst_i[11:7] != 5'd0);

endmodule

// File: rtl/idu_issue.sv
// Decode-and-issue stage: valid/ready input from the IFU, one output register
// toward the EXU, and a RUN/WAIT/HALT controller for jumps and ebreak/illegal.
//
// state | meaning
// RUN   | accepting instructions
// WAIT  | jal/jalr issued, fetch stalled until the EXU flushes
// HALT  | ebreak or illegal accepted, only reset leaves this state
module idu_issue
  import npc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [OP_W-1:0] out_alu_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rd,
  output logic            out_rd_wen,
  output logic            out_ebreak,
  output logic            out_illegal,
  output logic            halted
);

  logic [1:0]      state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] pc_q, imm_q;
  logic [OP_W-1:0] alu_op_q;
  logic [4:0]      rs1_q, rd_q;
  logic            rd_wen_q, ebreak_q, illegal_q;

  logic [OP_W-1:0] dec_alu_op;
  logic [XLEN-1:0] dec_imm;
  logic            dec_rd_wen, dec_ebreak, dec_illegal;
  logic            accept;

  idu_decode #(.XLEN(XLEN), .OP_W(OP_W)) u_decode (
    .inst_i    (in_inst),
    .alu_op_o  (dec_alu_op),
    .imm_o     (dec_imm),
    .rd_wen_o  (dec_rd_wen),
    .ebreak_o  (dec_ebreak),
    .illegal_o (dec_illegal)
  );

  assign in_ready = (state_q == ST_RUN) && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (accept && (dec_ebreak || dec_illegal)) state_d = ST_HALT;
        else if (accept && (dec_alu_op[ALU_JAL] || dec_alu_op[ALU_JALR])) state_d = ST_WAIT;
      end
      ST_WAIT: if (flush) state_d = ST_RUN;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  // flush discards a stalled entry, but in HALT the final entry must still issue
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush && (state_q != ST_HALT)) out_valid_d = 1'b0;
    else if (accept)                   out_valid_d = 1'b1;
    else if (out_ready)                out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      alu_op_q    <= '0;
      rs1_q       <= '0;
      rd_q        <= '0;
      rd_wen_q    <= 1'b0;
      ebreak_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        pc_q      <= in_pc;
        imm_q     <= dec_imm;
        alu_op_q  <= dec_alu_op;
        rs1_q     <= in_inst[19:15];
        rd_q      <= in_inst[11:7];
        rd_wen_q  <= dec_rd_wen;
        ebreak_q  <= dec_ebreak;
        illegal_q <= dec_illegal;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = pc_q;
  assign out_imm     = imm_q;
  assign out_alu_op  = alu_op_q;
  assign out_rs1     = rs1_q;
  assign out_rd      = rd_q;
  assign out_rd_wen  = rd_wen_q;
  assign out_ebreak  = ebreak_q;
  assign out_illegal = illegal_q;
  assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_idu_issue.sv
// Scoreboard bench for idu_issue: directed scenarios plus randomized traffic,
// checked against an instruction-level reference model.
module tb_idu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0;
  logic [31:0] in_inst = '0, in_pc = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_imm, out_alu_op;
  logic [4:0]  out_rs1, out_rd;
  logic        out_rd_wen, out_ebreak, out_illegal, halted;

  idu_issue #(.XLEN(32), .OP_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_imm(out_imm), .out_alu_op(out_alu_op), .out_rs1(out_rs1),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_ebreak(out_ebreak),
    .out_illegal(out_illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        ebreak;
    logic        illegal;
  } exp_t;

  localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   m_st = M_RUN;
  bit   m_full = 1'b0;

  function automatic exp_t ref_model(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int opc, f3, v;
    e = '0;
    e.pc  = pc;
    e.rs1 = w[19:15];
    e.rd  = w[11:7];
    opc = int'(w & 32'h7f);
    f3  = int'((w >> 12) & 32'h7);
    if (w == 32'h0010_0073) begin
      e.ebreak = 1'b1;
    end else if (opc == 'h37) begin
      e.alu_op = 2;
      e.imm = w - (w % 4096);
    end else if (opc == 'h17) begin
      e.alu_op = 1;
      e.imm = w - (w % 4096);
    end else if (opc == 'h6f) begin
      v = int'((w >> 21) & 32'h3ff) * 2 + int'((w >> 20) & 32'h1) * 2048
        + int'((w >> 12) & 32'hff) * 4096 - (w[31] ? (1 << 20) : 0);
      e.alu_op = 4;
      e.imm = v;
    end else if (opc == 'h67 && f3 == 0) begin
      e.alu_op = 8;
      e.imm = int'(w >> 20) - (w[31] ? 4096 : 0);
    end else if (opc == 'h13 && f3 == 0) begin
      e.alu_op = 16;
      e.imm = int'(w >> 20) - (w[31] ? 4096 : 0);
    end else begin
      e.illegal = 1'b1;
    end
    e.rd_wen = (e.alu_op != 0) && (e.rd != 0);
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    int k;
    logic [31:0] r;
    k = $urandom_range(0, 99);
    r = $urandom;
    if (k < 25)      return {r[31:15], ($urandom_range(0, 4) == 0) ? r[14:12] : 3'b000, r[11:7], 7'h13};
    else if (k < 40) return {r[31:7], 7'h37};
    else if (k < 55) return {r[31:7], 7'h17};
    else if (k < 66) return {r[31:7], 7'h6f};
    else if (k < 77) return {r[31:15], ($urandom_range(0, 4) == 0) ? r[14:12] : 3'b000, r[11:7], 7'h67};
    else if (k < 79) return 32'h0010_0073;
    else if (k < 82) return r;
    else             return {r[31:15], 3'b000, r[11:7], 7'h13};
  endfunction

  // Output monitor: every issued entry must match the oldest expected one.
  always @(negedge clk) begin
    exp_t e, got;
    if (!rst && out_valid && out_ready) begin
      vectors++;
      got = {out_pc, out_imm, out_alu_op, out_rs1, out_rd, out_rd_wen, out_ebreak, out_illegal};
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL issue_unexpected t=%0t got=%h expected=<none>", $time, got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL issue_payload t=%0t got=%h expected=%h", $time, got, e);
        end
      end
    end
  end

  // Called just after a rising edge; drives one cycle and advances the model.
  task automatic cycle(input bit v, input logic [31:0] w, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    bit   exp_rdy, acc;
    exp_t e, dropped;
    in_valid = v; in_inst = w; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = (m_st == M_RUN) && !fl && (!m_full || ordy);
    vectors++;
    if ({in_ready, halted, out_valid} !== {exp_rdy, (m_st == M_HALT), m_full}) begin
      miscompares++;
      $display("FAIL handshake t=%0t got rdy/halt/ov=%b%b%b expected=%b%b%b", $time,
               in_ready, halted, out_valid, exp_rdy, (m_st == M_HALT), m_full);
    end
    acc = v && exp_rdy;
    e = ref_model(w, pc);
    if (fl && m_st != M_HALT) begin
      if (m_full && !ordy && sb.size() > 0) dropped = sb.pop_front();
      m_full = 1'b0;
      if (m_st == M_WAIT) m_st = M_RUN;
    end else if (acc) begin
      sb.push_back(e);
      m_full = 1'b1;
      if (e.ebreak || e.illegal)       m_st = M_HALT;
      else if (e.alu_op[2] || e.alu_op[3]) m_st = M_WAIT;
    end else if (ordy) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted between edges; effect must be immediate.
  task automatic reset_mid();
    in_valid = 1'b0; flush = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, halted, in_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL async_reset t=%0t got ov/halt/rdy=%b%b%b expected=001", $time,
               out_valid, halted, in_ready);
    end
    sb.delete();
    m_st = M_RUN;
    m_full = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    #3;
    vectors++;
    if ({out_valid, halted, out_pc, out_imm, out_alu_op, out_rs1, out_rd,
         out_rd_wen, out_ebreak, out_illegal} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got ov=%b halt=%b pc=%h imm=%h op=%h", out_valid,
               halted, out_pc, out_imm, out_alu_op);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // addi x1,x0,5
    cycle(1, 32'h0050_0093, 32'h8000_0000, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // lui held for 3 stalled cycles, auipc passes through when ready rises
    cycle(1, 32'h1234_5137, 32'h8000_0004, 0, 0);
    repeat (3) cycle(1, 32'h0000_1197, 32'h8000_0008, 0, 0);
    cycle(1, 32'h0000_1197, 32'h8000_0008, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // jal x1,-8 then wait for flush
    cycle(1, 32'hFF9F_F0EF, 32'h8000_000C, 1, 0);
    repeat (2) cycle(1, 32'h0050_0093, 32'h8000_0004, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 1);
    cycle(1, 32'h0050_0093, 32'h8000_0004, 1, 0);

    // jalr x0,0(x1); input offered together with flush must be refused
    cycle(1, 32'h0000_8067, 32'h8000_0008, 1, 0);
    cycle(1, 32'h0050_0093, 32'h8000_0010, 1, 1);
    cycle(1, 32'h0050_0093, 32'h8000_0010, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // ebreak halts; flush and further input ignored
    cycle(1, 32'h0010_0073, 32'h8000_0014, 0, 0);
    cycle(1, 32'h0050_0093, 32'h8000_0018, 0, 1);
    cycle(1, 32'h0050_0093, 32'h8000_0018, 1, 0);
    repeat (3) cycle(1, 32'h0050_0093, 32'h8000_0018, 1, 1);
    reset_mid();

    // illegal word, stalled, then reset mid-stall
    cycle(1, 32'hFFFF_FFFF, 32'h8000_0020, 0, 0);
    repeat (2) cycle(1, 32'h0050_0093, 32'h8000_0024, 0, 0);
    reset_mid();

    for (int ep = 0; ep < 12; ep++) begin
      pc = 32'h8000_0000;
      for (int c = 0; c < 250; c++) begin
        cycle($urandom_range(0, 9) < 7, gen_inst(), pc,
              $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        pc = pc + 4;
      end
      reset_mid();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
